sram_rw_init_ext: RTL and testbench
===================================

Name: sram_rw_init_ext

Overview:
Parametrised single-port read/write SRAM model for cache data/tag arrays. It generalises the fixed-geometry RW ext memories with:
- configurable width, depth, mask granularity and read latency;
- a hardware initialisation sequencer that writes a known value to every entry after reset;
- a read-valid strobe;
- held (not random) read data.

It sits under cache tag/data array wrappers and replaces per-geometry ext modules.

Parameters:
ADDR_WIDTH, 10, address bits; depth = 2^ADDR_WIDTH entries
DATA_WIDTH, 32, bits per entry
MASK_GRAN, 8, bits per write-mask lane; DATA_WIDTH % MASK_GRAN == 0 (elaboration error otherwise); MASK_WIDTH = DATA_WIDTH/MASK_GRAN
READ_LATENCY, 1, cycles from accepted read to RW0_rdata/RW0_rvalid; legal 1..3
INIT_ON_RESET, 1, 1 = run init sweep after reset; 0 = array contents undefined, ready immediately
INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the sweep

Ports:
RW0_clk  in  1  clock; all state on posedge
reset  in  1  asynchronous, active-high reset
RW0_addr  in  ADDR_WIDTH  entry address
RW0_en  in  1  request valid
RW0_wmode  in  1  1 = write, 0 = read
RW0_wmask  in  MASK_WIDTH  per-lane write enable; ignored on reads
RW0_wdata  in  DATA_WIDTH  write data
RW0_rdata  out  DATA_WIDTH  read data; holds its value between reads
RW0_rvalid  out  1  one-cycle pulse when RW0_rdata carries new read data
init_busy  out  1  init sweep in progress; requests are not accepted
req_dropped  out  1  one-cycle pulse, registered, for a request presented while init_busy=1

Behaviour:
- Reset values (asynchronous):
  - RW0_rdata=0, RW0_rvalid=0, req_dropped=0.
  - init_busy=INIT_ON_RESET, init counter=0, read pipeline valid bits=0.
  - Array contents are not reset.
- FSM states INIT and READY; the reset state is INIT if INIT_ON_RESET=1, else READY.
  - INIT: each cycle writes INIT_VALUE (full mask) to entry cnt, then cnt++. The counter is ADDR_WIDTH+1 bits wide.
  - When cnt reaches depth-1 and that write completes, go to READY next cycle.
  - The sweep takes exactly 2^ADDR_WIDTH cycles after reset deassertion; init_busy falls on the first READY cycle.
  - READY: normal operation; never leaves except on reset.
- Reset asserted mid-sweep: the sweep restarts from entry 0 after deassertion. Reset asserted mid-read: pending rvalid pulses are discarded.
- Request accepted iff RW0_en=1 and state=READY.
- Write (wmode=1): at the accepting edge, lane k (bits k*MASK_GRAN+MASK_GRAN-1 : k*MASK_GRAN) is written iff wmask[k]. Unmasked lanes keep their old value. A wmask of all zeros writes nothing. No rvalid is produced.
- Read (wmode=0):
  - The array is sampled at the accepting edge and the data passes through a READ_LATENCY-stage pipeline.
  - RW0_rdata updates and RW0_rvalid=1 exactly READ_LATENCY edges after acceptance.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Write to address A in cycle N, then read A in cycle N+1: the read returns the newly written data.
- RW0_rdata changes only on rvalid; it holds its last value otherwise, including across writes.
- Request while INIT (RW0_en=1): no array effect, no rvalid; req_dropped=1 on the next cycle. A request on the first READY cycle is accepted.
- The init write and the address counter share the single array port; there is no user/init arbitration in READY.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum {INIT, READY};
  - the MASK_WIDTH derivation function;
  - the READ_LATENCY legality check macro/constant.
- One natural sub-module, sram_rd_pipe: a parametrised READ_LATENCY-deep data + valid shift register with asynchronous reset on the valid bits and the output data register.

Test Plan:
Bench parameters: ADDR_WIDTH=4, DATA_WIDTH=32, MASK_GRAN=8, INIT_VALUE=32'hA5A5_A5A5 unless stated.
1. Init sweep: deassert reset, hold RW0_en=0 → init_busy=1 for exactly 16 cycles then 0. Reading addresses 0..15 then returns 32'hA5A5_A5A5 each, with rvalid 1 cycle after each request (READ_LATENCY=1).
2. Masked write: write addr 3, wdata 32'h1122_3344, wmask 4'b0101, then read addr 3 → RW0_rdata=32'hA522_A544, rvalid one pulse.
3. Latency and pipelining: READ_LATENCY=3, writes addr0=1 and addr1=2, then back-to-back reads 0,1,0 → rvalid high on cycles +3, +4, +5 with data 1, 2, 1. RW0_rdata holds 1 afterwards.
4. Dropped request: read request at cycle 5 of the sweep → req_dropped pulses at cycle 6, no rvalid, sweep still ends at cycle 16. A read at the first READY cycle is accepted.
5. Reset mid-operation: assert reset at sweep cycle 8 and again with a read in flight (READ_LATENCY=2) → no rvalid pulse; init_busy=1, RW0_rdata=0 immediately. Full 16-cycle sweep restarts.
6. INIT_ON_RESET=0: init_busy=0 from reset. A write then read of addr 15, wdata 32'hDEAD_BEEF, wmask 4'hF, returns 32'hDEAD_BEEF.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the parametrised RW SRAM model.
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_t;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  function automatic int mask_width(input int data_w, input int gran);
    return data_w / gran;
  endfunction

  function automatic bit read_latency_ok(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: LATENCY-deep data + valid shift; each data stage only
// loads when its incoming valid is set, so the last stage holds between reads.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int STAGES = LATENCY - 1;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      if (in_valid) dat_pipe[0] <= in_data;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];

endmodule

// File: rtl/sram_rw_init_ext.sv
// Single-port RW SRAM model with lane write mask, post-reset init sweep,
// configurable read latency and held read data.
module sram_rw_init_ext
  import sram_pkg::*;
#(
  parameter int                  ADDR_WIDTH    = 10,
  parameter int                  DATA_WIDTH    = 32,
  parameter int                  MASK_GRAN     = 8,
  parameter int                  READ_LATENCY  = 1,
  parameter bit                  INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
  localparam int                 MASK_WIDTH    = mask_width(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [MASK_WIDTH-1:0] RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_rvalid,
  output logic                  init_busy,
  output logic                  req_dropped
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_gran_chk
    $error("sram_rw_init_ext: DATA_WIDTH must be a multiple of MASK_GRAN");
  end
  if (!read_latency_ok(READ_LATENCY)) begin : g_lat_chk
    $error("sram_rw_init_ext: READ_LATENCY out of range 1..3");
  end

  sram_state_t           state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  init_we;
  logic                  accept;
  logic                  rd_fire;
  logic [MASK_WIDTH-1:0] lane_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Nothing touches the array while reset is held.
  assign init_we = (state == INIT) && !reset;
  assign accept  = RW0_en && (state == READY) && !reset;
  assign rd_fire = accept && !RW0_wmode;

  // The sweep owns the single port in INIT; user traffic owns it in READY.
  always_comb begin
    lane_we = '0;
    wr_addr = RW0_addr;
    wr_data = RW0_wdata;
    if (init_we) begin
      lane_we = '1;
      wr_addr = init_cnt[ADDR_WIDTH-1:0];
      wr_data = INIT_VALUE;
    end else if (accept && RW0_wmode) begin
      lane_we = RW0_wmask;
    end
  end

  always_ff @(posedge RW0_clk) begin
    for (int k = 0; k < MASK_WIDTH; k++) begin
      if (lane_we[k]) mem[wr_addr][k*MASK_GRAN +: MASK_GRAN] <= wr_data[k*MASK_GRAN +: MASK_GRAN];
    end
  end

  assign rd_word = mem[RW0_addr];

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state       <= INIT_ON_RESET ? INIT : READY;
      init_cnt    <= '0;
      init_busy   <= INIT_ON_RESET;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= RW0_en && (state == INIT);
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_IDX) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: ;
        default: state <= READY;
      endcase
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_rd_pipe (
    .RW0_clk  (RW0_clk),
    .reset    (reset),
    .in_valid (rd_fire),
    .in_data  (rd_word),
    .out_valid(RW0_rvalid),
    .out_data (RW0_rdata)
  );

endmodule

// File: tb/tb_sram_rw_init_ext.sv
// Bench for sram_rw_init_ext: four instances (latency 1/3/2 with init, latency 1 without)
// share stimulus and are checked against a per-instance memory/arrival-schedule model.
module tb_sram_rw_init_ext;

  localparam int          NDUT  = 4;
  localparam int          MW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] IV    = 32'hA5A5_A5A5;
  localparam int          LAT [NDUT]      = '{1, 3, 2, 1};
  localparam bit          HAS_INIT [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, wm = 1'b0;
  logic [3:0]  addr = '0, mask = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd [NDUT];
  logic        rv [NDUT], busy [NDUT], drop [NDUT];

  int n_cmp = 0, n_fail = 0;

  // reference model
  logic [31:0] ref_mem [NDUT][DEPTH];
  bit          known   [NDUT][DEPTH];
  bit          sched_v [NDUT][8];
  logic [31:0] sched_d [NDUT][8];
  bit          sched_k [NDUT][8];
  bit          exp_rv [NDUT], exp_busy [NDUT], exp_drop [NDUT], exp_known [NDUT];
  logic [31:0] exp_rd [NDUT];
  int          cyc = 0, sweep_left = DEPTH;

  always #5 clk = ~clk;

  sram_rw_init_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(1),
    .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) u_dut_l1 (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rd[0]), .RW0_rvalid(rv[0]),
    .init_busy(busy[0]), .req_dropped(drop[0]));
  sram_rw_init_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(3),
    .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) u_dut_l3 (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rd[1]), .RW0_rvalid(rv[1]),
    .init_busy(busy[1]), .req_dropped(drop[1]));
  sram_rw_init_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(2),
    .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) u_dut_l2 (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rd[2]), .RW0_rvalid(rv[2]),
    .init_busy(busy[2]), .req_dropped(drop[2]));
  sram_rw_init_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(1),
    .INIT_ON_RESET(1'b0), .INIT_VALUE(IV)) u_dut_noinit (
    .RW0_clk(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rd[3]), .RW0_rvalid(rv[3]),
    .init_busy(busy[3]), .req_dropped(drop[3]));

  task automatic rst_assert();
    rst = 1'b1; en = 1'b0;
    #1;
    sweep_left = DEPTH;
    for (int d = 0; d < NDUT; d++) begin
      exp_rv[d] = 1'b0; exp_rd[d] = '0; exp_known[d] = 1'b1;
      exp_drop[d] = 1'b0; exp_busy[d] = HAS_INIT[d];
      for (int s = 0; s < 8; s++) sched_v[d][s] = 1'b0;
    end
  endtask

  task automatic rst_release();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock of stimulus; afterwards exp_* describe the outputs for the new cycle.
  task automatic step(input bit e, input bit w, input logic [3:0] a,
                      input logic [3:0] m, input logic [31:0] din);
    int slot;
    bit bz;
    en = e; wm = w; addr = a; mask = m; wdata = din;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      bz = HAS_INIT[d] && (sweep_left > 0);
      exp_drop[d] = e && bz;
      if (e && !bz) begin
        if (w) begin
          for (int k = 0; k < MW; k++) if (m[k]) ref_mem[d][a][k*8 +: 8] = din[k*8 +: 8];
          known[d][a] = known[d][a] || (m == 4'hF);
        end else begin
          slot = (cyc + LAT[d] - 1) % 8;
          sched_v[d][slot] = 1'b1;
          sched_d[d][slot] = ref_mem[d][a];
          sched_k[d][slot] = known[d][a];
        end
      end
      if (bz) begin
        ref_mem[d][DEPTH - sweep_left] = IV;
        known[d][DEPTH - sweep_left]   = 1'b1;
      end
      slot = cyc % 8;
      exp_rv[d] = sched_v[d][slot];
      if (sched_v[d][slot]) begin
        exp_rd[d] = sched_d[d][slot];
        exp_known[d] = sched_k[d][slot];
        sched_v[d][slot] = 1'b0;
      end
    end
    if (sweep_left > 0) sweep_left--;
    for (int d = 0; d < NDUT; d++) exp_busy[d] = HAS_INIT[d] && (sweep_left > 0);
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    #2;
    rst_assert();
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++; if (rv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, rv[d]); end
      n_cmp++; if (rd[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rd[d]); end
      n_cmp++; if (drop[d] !== 1'b0) begin n_fail++; $display("FAIL reset_dropped dut%0d: got %b want 0", d, drop[d]); end
      n_cmp++; if (busy[d] !== HAS_INIT[d]) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want %b", d, busy[d], HAS_INIT[d]); end
    end
  endtask

  task automatic test_init_sweep();
    int nb, np;
    rst_release();
    nb = busy[0] ? 1 : 0;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      idle();
      if (busy[0]) nb++;
    end
    n_cmp++; if (nb !== 16) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d want 16", nb); end
    np = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      step(i < DEPTH, 1'b0, 4'(i), 4'd0, 32'd0);
      n_cmp++; if (rv[0] !== exp_rv[0]) begin n_fail++; $display("FAIL sweep_rd_rvalid i=%0d: got %b want %b", i, rv[0], exp_rv[0]); end
      if (rv[0]) begin
        np++;
        n_cmp++; if (rd[0] !== IV) begin n_fail++; $display("FAIL sweep_rd_data i=%0d: got %h want %h", i, rd[0], IV); end
      end
    end
    n_cmp++; if (np !== 16) begin n_fail++; $display("FAIL sweep_rd_pulses: got %0d want 16", np); end
  endtask

  task automatic test_masked_write();
    step(1'b1, 1'b1, 4'd3, 4'b0101, 32'h1122_3344);
    step(1'b1, 1'b0, 4'd3, 4'd0, 32'd0);
    n_cmp++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL mask_rvalid: got %b want 1", rv[0]); end
    n_cmp++; if (rd[0] !== 32'hA522_A544) begin n_fail++; $display("FAIL mask_rdata: got %h want a522a544", rd[0]); end
    step(1'b1, 1'b1, 4'd3, 4'hF, 32'h0BAD_F00D);
    n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL mask_rvalid_pulse: got %b want 0", rv[0]); end
    idle();
    n_cmp++; if (rd[0] !== 32'hA522_A544) begin n_fail++; $display("FAIL mask_rdata_hold: got %h want a522a544", rd[0]); end
    step(1'b1, 1'b0, 4'd3, 4'd0, 32'd0);
    n_cmp++; if (rd[0] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wr_then_rd: got %h want 0badf00d", rd[0]); end
  endtask

  task automatic test_latency_pipeline();
    int          hits;
    int          exp_cyc [3] = '{3, 4, 5};
    logic [31:0] exp_dat [3] = '{32'd1, 32'd2, 32'd1};
    step(1'b1, 1'b1, 4'd0, 4'hF, 32'd1);
    step(1'b1, 1'b1, 4'd1, 4'hF, 32'd2);
    hits = 0;
    for (int s = 0; s < 8; s++) begin
      step(s < 3, 1'b0, (s == 1) ? 4'd1 : 4'd0, 4'd0, 32'd0);
      n_cmp++; if (rv[1] !== exp_rv[1]) begin n_fail++; $display("FAIL lat3_rvalid s=%0d: got %b want %b", s, rv[1], exp_rv[1]); end
      if (rv[1]) begin
        if (hits < 3) begin
          n_cmp++; if (s + 1 !== exp_cyc[hits]) begin n_fail++; $display("FAIL lat3_cycle: got +%0d want +%0d", s + 1, exp_cyc[hits]); end
          n_cmp++; if (rd[1] !== exp_dat[hits]) begin n_fail++; $display("FAIL lat3_data: got %h want %h", rd[1], exp_dat[hits]); end
        end
        hits++;
      end
    end
    n_cmp++; if (hits !== 3) begin n_fail++; $display("FAIL lat3_pulses: got %0d want 3", hits); end
    n_cmp++; if (rd[1] !== 32'd1) begin n_fail++; $display("FAIL lat3_hold: got %h want 1", rd[1]); end
  endtask

  task automatic test_dropped();
    int nb, nd;
    rst_assert();
    rst_release();
    nb = busy[0] ? 1 : 0;
    nd = 0;
    for (int k = 0; k < 16; k++) begin
      step(k == 5, 1'b0, 4'd7, 4'd0, 32'd0);
      if (busy[0]) nb++;
      if (drop[0]) nd++;
      n_cmp++; if (drop[0] !== exp_drop[0]) begin n_fail++; $display("FAIL drop_pulse k=%0d: got %b want %b", k, drop[0], exp_drop[0]); end
      n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL drop_no_rvalid k=%0d: got %b want 0", k, rv[0]); end
    end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL drop_count: got %0d want 1", nd); end
    n_cmp++; if (nb !== 16) begin n_fail++; $display("FAIL drop_sweep_len: got %0d want 16", nb); end
    step(1'b1, 1'b0, 4'd2, 4'd0, 32'd0);
    n_cmp++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL first_ready_rvalid: got %b want 1", rv[0]); end
    n_cmp++; if (rd[0] !== IV) begin n_fail++; $display("FAIL first_ready_rdata: got %h want %h", rd[0], IV); end
  endtask

  task automatic test_reset_mid();
    int nb, np;
    logic [31:0] val;
    rst_assert();
    rst_release();
    repeat (8) idle();
    rst_assert();
    n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL midsweep_busy: got %b want 1", busy[0]); end
    rst_release();
    nb = busy[0] ? 1 : 0;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      idle();
      if (busy[0]) nb++;
    end
    n_cmp++; if (nb !== 16) begin n_fail++; $display("FAIL midsweep_restart_len: got %0d want 16", nb); end
    val = $urandom | 32'h1;
    step(1'b1, 1'b1, 4'd5, 4'hF, val);
    step(1'b1, 1'b0, 4'd5, 4'd0, 32'd0);
    idle();
    n_cmp++; if (rd[2] !== val) begin n_fail++; $display("FAIL lat2_rdata: got %h want %h", rd[2], val); end
    step(1'b1, 1'b0, 4'd5, 4'd0, 32'd0);
    rst_assert();
    n_cmp++; if (rv[2] !== 1'b0) begin n_fail++; $display("FAIL midread_rvalid: got %b want 0", rv[2]); end
    n_cmp++; if (rd[2] !== 32'd0) begin n_fail++; $display("FAIL midread_rdata: got %h want 0", rd[2]); end
    n_cmp++; if (busy[2] !== 1'b1) begin n_fail++; $display("FAIL midread_busy: got %b want 1", busy[2]); end
    rst_release();
    nb = busy[2] ? 1 : 0;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (busy[2]) nb++;
      if (rv[2]) np++;
    end
    n_cmp++; if (np !== 0) begin n_fail++; $display("FAIL midread_discard: got %0d pulses want 0", np); end
    n_cmp++; if (nb !== 16) begin n_fail++; $display("FAIL midread_sweep_len: got %0d want 16", nb); end
  endtask

  task automatic test_noinit();
    rst_assert();
    rst_release();
    n_cmp++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL noinit_busy: got %b want 0", busy[3]); end
    step(1'b1, 1'b1, 4'd15, 4'hF, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 4'd15, 4'd0, 32'd0);
    n_cmp++; if (rv[3] !== 1'b1) begin n_fail++; $display("FAIL noinit_rvalid: got %b want 1", rv[3]); end
    n_cmp++; if (rd[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL noinit_rdata: got %h want deadbeef", rd[3]); end
    n_cmp++; if (drop[0] !== 1'b1) begin n_fail++; $display("FAIL noinit_peer_drop: got %b want 1", drop[0]); end
  endtask

  task automatic test_back_to_back();
    while (sweep_left > 0) idle();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
      for (int d = 0; d < NDUT; d++) begin
        n_cmp++; if (rv[d] !== exp_rv[d]) begin n_fail++; $display("FAIL rand_rvalid dut%0d i=%0d: got %b want %b", d, i, rv[d], exp_rv[d]); end
        if (exp_known[d]) begin
          n_cmp++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL rand_rdata dut%0d i=%0d: got %h want %h", d, i, rd[d], exp_rd[d]); end
        end
        n_cmp++; if (busy[d] !== exp_busy[d]) begin n_fail++; $display("FAIL rand_busy dut%0d i=%0d: got %b want %b", d, i, busy[d], exp_busy[d]); end
        n_cmp++; if (drop[d] !== exp_drop[d]) begin n_fail++; $display("FAIL rand_dropped dut%0d i=%0d: got %b want %b", d, i, drop[d], exp_drop[d]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_latency_pipeline();
    test_dropped();
    test_reset_mid();
    test_noinit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
